// File: rtl/alarm_ctrl_pkg.sv
// Shared types and default timing constants for the alarm sequencer.
package alarm_ctrl_pkg;

    typedef enum logic [1:0] {
        DISARMED = 2'd0,
        ARMED    = 2'd1,
        RINGING  = 2'd2,
        SNOOZED  = 2'd3
    } alarm_state_t;

    localparam int unsigned RING_SEC_DEF   = 32'd60;
    localparam int unsigned SNOOZE_SEC_DEF = 32'd300;
    localparam int unsigned SNOOZE_MAX_DEF = 32'd3;

endpackage

// File: rtl/alarm_ctrl_if.sv
// Button/tick/comparator inputs and buzzer/status outputs of the alarm sequencer.
interface alarm_ctrl_if #(
    parameter int unsigned SNOOZE_MAX = alarm_ctrl_pkg::SNOOZE_MAX_DEF
);
    localparam int unsigned SCW = $clog2(SNOOZE_MAX + 1);

    logic           sec_tick;
    logic           equal;
    logic           arm;
    logic           disarm;
    logic           stop;
    logic           snooze;
    logic           cmp_enable;
    logic           buzzer;
    logic           ringing;
    logic           snoozing;
    logic           missed;
    logic [SCW-1:0] snooze_cnt;

    modport master (
        output sec_tick, equal, arm, disarm, stop, snooze,
        input  cmp_enable, buzzer, ringing, snoozing, missed, snooze_cnt
    );

    modport slave (
        input  sec_tick, equal, arm, disarm, stop, snooze,
        output cmp_enable, buzzer, ringing, snoozing, missed, snooze_cnt
    );

endinterface

// File: rtl/alarm_ctrl_sec_down_cnt.sv
// Loadable, tick-enabled, saturating seconds down counter; expire_o marks the tick that leaves 1.
module sec_down_cnt
    import alarm_ctrl_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         tick_i,
    output logic         expire_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Load wins over tick; the count sticks at zero instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (tick_i && (cnt_q != {W{1'b0}})) begin
            cnt_d = cnt_q - W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= {W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = tick_i && (cnt_q == W'(1));

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm sequencer: enables the time comparator and turns its match level into
// a ring / snooze / timeout cycle driving the buzzer.
module alarm_ctrl
    import alarm_ctrl_pkg::*;
#(
    parameter int unsigned RING_SEC   = RING_SEC_DEF,
    parameter int unsigned SNOOZE_SEC = SNOOZE_SEC_DEF,
    parameter int unsigned SNOOZE_MAX = SNOOZE_MAX_DEF
) (
    input  logic        mclk,
    input  logic        rst,
    alarm_ctrl_if.slave bus
);

    localparam int unsigned RCW = $clog2(RING_SEC + 1);
    localparam int unsigned ZCW = $clog2(SNOOZE_SEC + 1);
    localparam int unsigned SCW = $clog2(SNOOZE_MAX + 1);

    alarm_state_t   state_q, state_d;
    logic           equal_d_q;
    logic           beep_q, beep_d;
    logic           missed_q, missed_d;
    logic [SCW-1:0] snooze_cnt_q, snooze_cnt_d;

    logic equal_rise;
    logic snooze_ok;
    logic ring_load;
    logic snz_load;
    logic ring_expire;
    logic snz_expire;

    assign equal_rise = bus.equal & ~equal_d_q;
    assign snooze_ok  = bus.snooze && (snooze_cnt_q < SCW'(SNOOZE_MAX));

    sec_down_cnt #(.W(RCW)) u_ring_tmr (
        .clk        (mclk),
        .rst        (rst),
        .load_i     (ring_load),
        .load_val_i (RCW'(RING_SEC)),
        .tick_i     (bus.sec_tick && (state_q == RINGING)),
        .expire_o   (ring_expire)
    );

    sec_down_cnt #(.W(ZCW)) u_snz_tmr (
        .clk        (mclk),
        .rst        (rst),
        .load_i     (snz_load),
        .load_val_i (ZCW'(SNOOZE_SEC)),
        .tick_i     (bus.sec_tick && (state_q == SNOOZED)),
        .expire_o   (snz_expire)
    );

    // Next state; a command only outranks an event when it acts in the current state.
    always_comb begin
        state_d      = state_q;
        beep_d       = beep_q;
        missed_d     = missed_q;
        snooze_cnt_d = snooze_cnt_q;
        ring_load    = 1'b0;
        snz_load     = 1'b0;
        if (bus.disarm) begin
            state_d = DISARMED;
        end else begin
            case (state_q)
                DISARMED: begin
                    if (bus.arm) begin
                        state_d  = ARMED;
                        missed_d = 1'b0;
                    end else begin
                        state_d = DISARMED;
                    end
                end
                ARMED: begin
                    if (equal_rise) begin
                        state_d      = RINGING;
                        ring_load    = 1'b1;
                        snooze_cnt_d = {SCW{1'b0}};
                        beep_d       = 1'b1;
                    end else begin
                        state_d = ARMED;
                    end
                end
                RINGING: begin
                    if (bus.stop) begin
                        state_d = ARMED;
                    end else if (snooze_ok) begin
                        state_d      = SNOOZED;
                        snz_load     = 1'b1;
                        snooze_cnt_d = snooze_cnt_q + SCW'(1);
                    end else if (ring_expire) begin
                        state_d  = ARMED;
                        missed_d = 1'b1;
                    end else if (bus.sec_tick) begin
                        beep_d = ~beep_q;
                    end else begin
                        beep_d = beep_q;
                    end
                end
                SNOOZED: begin
                    if (bus.stop) begin
                        state_d = ARMED;
                    end else if (snz_expire) begin
                        state_d   = RINGING;
                        ring_load = 1'b1;
                        beep_d    = 1'b1;
                    end else begin
                        state_d = SNOOZED;
                    end
                end
                default: begin
                    state_d = DISARMED;
                end
            endcase
        end
    end

    // State and status registers.
    always_ff @(posedge mclk) begin
        if (rst) begin
            state_q      <= DISARMED;
            equal_d_q    <= 1'b0;
            beep_q       <= 1'b0;
            missed_q     <= 1'b0;
            snooze_cnt_q <= {SCW{1'b0}};
        end else begin
            state_q      <= state_d;
            equal_d_q    <= bus.equal;
            beep_q       <= beep_d;
            missed_q     <= missed_d;
            snooze_cnt_q <= snooze_cnt_d;
        end
    end

    assign bus.cmp_enable = (state_q != DISARMED);
    assign bus.ringing    = (state_q == RINGING);
    assign bus.snoozing   = (state_q == SNOOZED);
    assign bus.buzzer     = (state_q == RINGING) && beep_q;
    assign bus.missed     = missed_q;
    assign bus.snooze_cnt = snooze_cnt_q;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Bench for alarm_ctrl: directed scenarios plus random button traffic against a seconds-level model.
module tb_alarm_ctrl;

    localparam int RS = 4;
    localparam int SS = 3;
    localparam int SM = 2;
    localparam int M_OFF   = 0;
    localparam int M_ARMED = 1;
    localparam int M_RING  = 2;
    localparam int M_SNZ   = 3;

    logic mclk = 1'b0;
    logic rst  = 1'b1;

    alarm_ctrl_if #(.SNOOZE_MAX(SM)) bus();

    alarm_ctrl #(.RING_SEC(RS), .SNOOZE_SEC(SS), .SNOOZE_MAX(SM)) dut (
        .mclk (mclk),
        .rst  (rst),
        .bus  (bus)
    );

    always #5 mclk = ~mclk;

    int checks   = 0;
    int failures = 0;
    int div      = 0;
    bit match    = 1'b0;
    bit eq_q     = 1'b0;

    int m_mode     = M_OFF;
    int m_elapsed  = 0;
    int m_snz_left = 0;
    int m_scnt     = 0;
    bit m_missed   = 1'b0;
    bit m_eq_prev  = 1'b0;

    task automatic check_val(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    // One mclk of alarm behaviour in terms of seconds rung and seconds left.
    task automatic model_step(input bit r, input bit a, input bit d, input bit s,
                              input bit z, input bit t, input bit e);
        bit rise;
        rise      = e && !m_eq_prev;
        m_eq_prev = e;
        if (r) begin
            m_mode = M_OFF; m_elapsed = 0; m_snz_left = 0;
            m_scnt = 0; m_missed = 1'b0; m_eq_prev = 1'b0;
        end else if (d) begin
            m_mode = M_OFF;
        end else begin
            case (m_mode)
                M_OFF: if (a) begin m_mode = M_ARMED; m_missed = 1'b0; end
                M_ARMED: if (rise) begin m_mode = M_RING; m_elapsed = 0; m_scnt = 0; end
                M_RING: begin
                    if (s) m_mode = M_ARMED;
                    else if (z && m_scnt < SM) begin
                        m_mode = M_SNZ; m_snz_left = SS; m_scnt++;
                    end else if (t) begin
                        m_elapsed++;
                        if (m_elapsed == RS) begin m_mode = M_ARMED; m_missed = 1'b1; end
                    end
                end
                M_SNZ: begin
                    if (s) m_mode = M_ARMED;
                    else if (t) begin
                        m_snz_left--;
                        if (m_snz_left == 0) begin m_mode = M_RING; m_elapsed = 0; end
                    end
                end
                default: m_mode = M_OFF;
            endcase
        end
    endtask

    task automatic check_all();
        check_val("cmp_enable", bus.cmp_enable, m_mode != M_OFF);
        check_val("buzzer", bus.buzzer, (m_mode == M_RING) && (m_elapsed % 2 == 0));
        check_val("ringing", bus.ringing, m_mode == M_RING);
        check_val("snoozing", bus.snoozing, m_mode == M_SNZ);
        check_val("missed", bus.missed, m_missed);
        check_val("snooze_cnt", bus.snooze_cnt, m_scnt);
    endtask

    // Drive one cycle from a negedge, also modelling the registered comparator.
    task automatic cycle(input bit a, input bit d, input bit s, input bit z);
        bit t;
        bit cmp_pre;
        t            = (div == 9);
        bus.arm      = a;
        bus.disarm   = d;
        bus.stop     = s;
        bus.snooze   = z;
        bus.sec_tick = t;
        bus.equal    = eq_q;
        cmp_pre      = (m_mode != M_OFF);
        model_step(rst, a, d, s, z, t, eq_q);
        @(posedge mclk);
        eq_q = rst ? 1'b0 : (cmp_pre && match);
        div  = (div + 1) % 10;
        #1;
        check_all();
        @(negedge mclk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int n;
        bus.arm = 1'b0; bus.disarm = 1'b0; bus.stop = 1'b0;
        bus.snooze = 1'b0; bus.sec_tick = 1'b0; bus.equal = 1'b0;
        @(negedge mclk);

        // Ring to timeout
        rst = 1'b1; idle(2); rst = 1'b0; idle(1);
        check_val("rst_cmp_enable", bus.cmp_enable, 0);
        check_val("rst_snooze_cnt", bus.snooze_cnt, 0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        idle(2);
        match = 1'b1; idle(2);
        check_val("t1_ring_start", bus.ringing, 1);
        check_val("t1_buzz_start", bus.buzzer, 1);
        idle(45);
        check_val("t1_missed", bus.missed, 1);
        check_val("t1_ring_end", bus.ringing, 0);
        check_val("t1_buzz_end", bus.buzzer, 0);

        // Stop with equal still high: no re-ring until a fresh rise
        match = 1'b0; idle(3); match = 1'b1; idle(3);
        check_val("t2_ring", bus.ringing, 1);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        check_val("t2_stopped", bus.ringing, 0);
        idle(30);
        check_val("t2_no_rering", bus.ringing, 0);
        match = 1'b0; idle(3); match = 1'b1; idle(3);
        check_val("t2_rering", bus.ringing, 1);

        // Snooze limit
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check_val("t3_snz1", bus.snoozing, 1);
        idle(32);
        check_val("t3_ring2", bus.ringing, 1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check_val("t3_snz2", bus.snoozing, 1);
        idle(32);
        check_val("t3_ring3", bus.ringing, 1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check_val("t3_snz_ignored", bus.ringing, 1);
        check_val("t3_snz_cnt", bus.snooze_cnt, 2);

        // Re-arm clears missed; stop+snooze; snooze on the expiring tick
        cycle(1'b0, 1'b1, 1'b0, 1'b0); idle(2);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        check_val("t4_missed_clr", bus.missed, 0);
        idle(2);
        check_val("t4_ring", bus.ringing, 1);
        cycle(1'b0, 1'b0, 1'b1, 1'b1);
        check_val("t4_stop_wins", bus.ringing | bus.snoozing, 0);
        check_val("t4_cnt_kept", bus.snooze_cnt, 0);
        match = 1'b0; idle(3); match = 1'b1; idle(3);
        n = 0;
        while (!(m_mode == M_RING && m_elapsed == RS - 1 && div == 9) && n < 60) begin
            idle(1); n++;
        end
        check_val("t4_wait_last_sec", n < 60, 1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check_val("t4_snz_wins", bus.snoozing, 1);
        check_val("t4_not_missed", bus.missed, 0);

        // Disarm while snoozed, then arm inside the matching minute
        idle(2);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        check_val("t5_cmp_off", bus.cmp_enable, 0);
        check_val("t5_cnt_kept", bus.snooze_cnt, 1);
        idle(2);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        check_val("t5_arm_c0", bus.ringing, 0);
        idle(1);
        check_val("t5_arm_c1", bus.ringing, 0);
        idle(1);
        check_val("t5_arm_c2", bus.ringing, 1);

        // Reset mid-ring, arm ignored under reset
        rst = 1'b1;
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        check_val("t6_ring", bus.ringing, 0);
        check_val("t6_cmp", bus.cmp_enable, 0);
        check_val("t6_cnt", bus.snooze_cnt, 0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        rst = 1'b0; idle(3);
        check_val("t6_still_off", bus.cmp_enable, 0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) match = ~match;
            rst = ($urandom_range(0, 599) == 0);
            cycle($urandom_range(0, 19) == 0, $urandom_range(0, 99) == 0,
                  $urandom_range(0, 24) == 0, $urandom_range(0, 9) == 0);
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
